// File: rtl/jzjpcc_pkg.sv
// Shared definitions for the jzjpcc pipeline: rd source selector, load funct3 codes
// and the hard-wired zero register address.
package jzjpcc_pkg;

    typedef enum logic [1:0] {
        RD_ALU = 2'b00,
        RD_MEM = 2'b01
    } rd_source_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [4:0] X0_ADDR = 5'd0;

endpackage

// File: rtl/jzjpcc_load_extractor.sv
// Combinational load alignment: picks the byte/halfword/word out of the SRAM word,
// extends it, and flags misaligned or undefined load encodings.
module jzjpcc_load_extractor
    import jzjpcc_pkg::*;
(
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_load_i,
    output logic [31:0] data_o,
    output logic        fault_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;
    logic        bad;

    always_comb begin
        byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
        half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
        ext      = 32'd0;
        bad      = 1'b0;
        case (funct3_i)
            F3_LB:  ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: ext = {24'd0, byte_sel};
            F3_LH: begin
                ext = {{16{half_sel[15]}}, half_sel};
                bad = byte_off_i[0];
            end
            F3_LHU: begin
                ext = {16'd0, half_sel};
                bad = byte_off_i[0];
            end
            F3_LW: begin
                ext = word_i;
                bad = (byte_off_i != 2'b00);
            end
            default: bad = 1'b1;
        endcase
    end

    // A faulting load contributes zero so nothing stale leaks into writeback.
    assign fault_o = is_load_i & bad;
    assign data_o  = fault_o ? 32'd0 : ext;

endmodule

// File: rtl/jzjpcc_memory.sv
// Memory stage: selects the rd value, registers it into writeback with stall/flush
// control, keeps a sticky misaligned-load flag and exposes forwarding taps.
module jzjpcc_memory
    import jzjpcc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] aluResult,
    input  logic [4:0]  rdAddr,
    input  logic [1:0]  rdSource,
    input  logic        rdWriteEnable,
    input  logic [2:0]  funct3,
    input  logic [31:0] memReadData,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  wbRdAddr,
    output logic [31:0] wbRdData,
    output logic        wbRdWriteEnable,
    output logic [4:0]  fwdRdAddr,
    output logic        fwdRdWriteEnable,
    output logic        fwdIsLoad,
    output logic        misalignedLoad
);

    logic        is_load;
    logic        fault;
    logic [31:0] load_data;

    logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
    logic [31:0] wb_rd_data_q, wb_rd_data_d;
    logic        wb_we_q, wb_we_d;
    logic        misaligned_q;

    // Encodings 2'b10/2'b11 fall through to the ALU path.
    assign is_load = (rdSource == RD_MEM);

    jzjpcc_load_extractor u_load_extractor (
        .byte_off_i (aluResult[1:0]),
        .word_i     (memReadData),
        .funct3_i   (funct3),
        .is_load_i  (is_load),
        .data_o     (load_data),
        .fault_o    (fault)
    );

    assign wb_rd_addr_d = rdAddr;
    assign wb_rd_data_d = is_load ? load_data : aluResult;
    assign wb_we_d      = rdWriteEnable & ~fault & (rdAddr != X0_ADDR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_rd_addr_q <= 5'd0;
            wb_rd_data_q <= 32'd0;
            wb_we_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            // Flush beats stall: the bubble only needs the write enable cleared.
            if (flush) begin
                wb_we_q <= 1'b0;
            end else if (!stall) begin
                wb_rd_addr_q <= wb_rd_addr_d;
                wb_rd_data_q <= wb_rd_data_d;
                wb_we_q      <= wb_we_d;
            end
            if (fault && !stall) begin
                misaligned_q <= 1'b1;
            end
        end
    end

    assign wbRdAddr         = wb_rd_addr_q;
    assign wbRdData         = wb_rd_data_q;
    assign wbRdWriteEnable  = wb_we_q;
    assign misalignedLoad   = misaligned_q;

    assign fwdRdAddr        = rdAddr;
    assign fwdRdWriteEnable = rdWriteEnable & (rdAddr != X0_ADDR);
    assign fwdIsLoad        = is_load;

endmodule

// File: tb/tb_jzjpcc_memory.sv
// Self-checking bench for jzjpcc_memory: directed load/stall/flush/reset cases plus
// randomized traffic against a behavioural model of the stage.
module tb_jzjpcc_memory;

    logic        clock;
    logic        reset;
    logic [31:0] aluResult;
    logic [4:0]  rdAddr;
    logic [1:0]  rdSource;
    logic        rdWriteEnable;
    logic [2:0]  funct3;
    logic [31:0] memReadData;
    logic        stall;
    logic        flush;
    logic [4:0]  wbRdAddr;
    logic [31:0] wbRdData;
    logic        wbRdWriteEnable;
    logic [4:0]  fwdRdAddr;
    logic        fwdRdWriteEnable;
    logic        fwdIsLoad;
    logic        misalignedLoad;

    int checks = 0;
    int errors = 0;

    // Model state: what writeback should hold after the last edge.
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_we;
    logic        m_flag;
    logic        m_known;

    jzjpcc_memory dut (
        .clock            (clock),
        .reset            (reset),
        .aluResult        (aluResult),
        .rdAddr           (rdAddr),
        .rdSource         (rdSource),
        .rdWriteEnable    (rdWriteEnable),
        .funct3           (funct3),
        .memReadData      (memReadData),
        .stall            (stall),
        .flush            (flush),
        .wbRdAddr         (wbRdAddr),
        .wbRdData         (wbRdData),
        .wbRdWriteEnable  (wbRdWriteEnable),
        .fwdRdAddr        (fwdRdAddr),
        .fwdRdWriteEnable (fwdRdWriteEnable),
        .fwdIsLoad        (fwdIsLoad),
        .misalignedLoad   (misalignedLoad)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_fault(input logic [1:0] src, input logic [2:0] f3,
                                         input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        if (src != 2'b01) return 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) return 1'b1;
        if (f3 == 3'd2 && off != 0) return 1'b1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int off;
        logic [31:0] b, h;
        logic signed [31:0] t;
        off = int'(addr % 4);
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (8 * off)) & 32'hFFFF;
        case (f3)
            3'd0: begin t = $signed(b << 24); return t >>> 24; end
            3'd4: return b;
            3'd1: begin t = $signed(h << 16); return t >>> 16; end
            3'd5: return h;
            default: return word;
        endcase
    endfunction

    task automatic model_reset();
        m_addr = 5'd0; m_data = 32'd0; m_we = 1'b0; m_flag = 1'b0; m_known = 1'b1;
    endtask

    task automatic check_wb(input string tag);
        check({tag, "_we"}, {31'd0, wbRdWriteEnable}, {31'd0, m_we});
        check({tag, "_flag"}, {31'd0, misalignedLoad}, {31'd0, m_flag});
        if (m_known) begin
            check({tag, "_addr"}, {27'd0, wbRdAddr}, {27'd0, m_addr});
            check({tag, "_data"}, wbRdData, m_data);
        end
    endtask

    // Applies one cycle of inputs, checks the forwarding taps, then the registered result.
    task automatic drive_cycle(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                               input logic [1:0] src, input logic we, input logic [2:0] f3,
                               input logic [31:0] word, input logic stl, input logic fl);
        logic flt;
        aluResult = addr; rdAddr = rd; rdSource = src; rdWriteEnable = we;
        funct3 = f3; memReadData = word; stall = stl; flush = fl;
        #1;
        check({tag, "_fwd_addr"}, {27'd0, fwdRdAddr}, {27'd0, rd});
        check({tag, "_fwd_we"}, {31'd0, fwdRdWriteEnable}, {31'd0, we && rd != 0});
        check({tag, "_fwd_ld"}, {31'd0, fwdIsLoad}, {31'd0, src == 2'b01});
        flt = model_fault(src, f3, addr);
        if (fl) begin
            m_we = 1'b0;
            m_known = 1'b0;
        end else if (!stl) begin
            m_addr = rd;
            m_data = (src == 2'b01) ? (flt ? 32'd0 : model_load(f3, addr, word)) : addr;
            m_we = we && !flt && rd != 0;
            m_known = 1'b1;
        end
        if (flt && !stl) m_flag = 1'b1;
        @(posedge clock);
        #1;
        check_wb(tag);
    endtask

    initial begin
        reset = 1'b1;
        aluResult = '0; rdAddr = '0; rdSource = '0; rdWriteEnable = 1'b0;
        funct3 = '0; memReadData = '0; stall = 1'b0; flush = 1'b0;
        model_reset();
        #1;
        check_wb("reset");
        #11;
        reset = 1'b0;

        // Byte/halfword loads with sign and zero extension.
        drive_cycle("lb", 32'h103, 5'd7, 2'b01, 1'b1, 3'b000, 32'h80FF1234, 1'b0, 1'b0);
        check("lb_const", wbRdData, 32'hFFFFFF80);
        check("lb_we_const", {31'd0, wbRdWriteEnable}, 32'd1);
        drive_cycle("lhu", 32'h102, 5'd8, 2'b01, 1'b1, 3'b101, 32'hBEEF0001, 1'b0, 1'b0);
        check("lhu_const", wbRdData, 32'h0000BEEF);
        drive_cycle("lh", 32'h102, 5'd8, 2'b01, 1'b1, 3'b001, 32'hBEEF0001, 1'b0, 1'b0);
        check("lh_const", wbRdData, 32'hFFFFBEEF);

        // Misaligned word load sets the sticky flag.
        drive_cycle("lw_mis", 32'h101, 5'd9, 2'b01, 1'b1, 3'b010, 32'h11223344, 1'b0, 1'b0);
        check("lw_mis_we", {31'd0, wbRdWriteEnable}, 32'd0);
        check("lw_mis_flag", {31'd0, misalignedLoad}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive_cycle("legal", 32'h200 + 32'(4 * i), 5'(i + 1), 2'b00, 1'b1, 3'b010,
                        $urandom, 1'b0, 1'b0);
        end
        check("flag_sticky", {31'd0, misalignedLoad}, 32'd1);

        // Stall holds prior values, then first free edge captures.
        drive_cycle("pre", 32'hAAAA0000, 5'd3, 2'b00, 1'b1, 3'b000, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle("stall", 32'h12345678, 5'd5, 2'b00, 1'b1, 3'b000, 32'h0, 1'b1, 1'b0);
            check("stall_hold", wbRdData, 32'hAAAA0000);
        end
        drive_cycle("unstall", 32'h12345678, 5'd5, 2'b00, 1'b1, 3'b000, 32'h0, 1'b0, 1'b0);
        check("unstall_data", wbRdData, 32'h12345678);

        drive_cycle("stfl", 32'h55, 5'd6, 2'b00, 1'b1, 3'b000, 32'h0, 1'b1, 1'b1);
        check("stfl_we", {31'd0, wbRdWriteEnable}, 32'd0);
        drive_cycle("x0", 32'h77, 5'd0, 2'b00, 1'b1, 3'b000, 32'h0, 1'b0, 1'b0);
        check("x0_we", {31'd0, wbRdWriteEnable}, 32'd0);
        check("x0_addr", {27'd0, wbRdAddr}, 32'd0);

        // Asynchronous reset mid-cycle with a pending write.
        drive_cycle("pre_rst", 32'hCAFE, 5'd4, 2'b00, 1'b1, 3'b000, 32'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_wb("async_rst");
        @(posedge clock);
        #3;
        reset = 1'b0;
        drive_cycle("post_rst", 32'h1234, 5'd2, 2'b00, 1'b1, 3'b000, 32'h0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_cycle("rand", $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                        $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jzjpcc_memory.md
JZJPCC_MEMORY -- requirements
Module: jzjpcc_memory

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL provide ports `clock`, input, 1, the single rising-edge clock; all state is clocked on it.
REQ-003 SHALL provide ports `reset`, input, 1, asynchronous, active-high reset.
REQ-004 SHALL provide ports `aluResult`, input, 32, the execute-registered ALU result, also used as the byte address.
REQ-005 SHALL provide ports `rdAddr`, input, 5, the execute-registered destination register.
REQ-006 SHALL provide ports `rdSource`, input, 2, an `rd_source_t` value: `RD_ALU`=2'b00, `RD_MEM`=2'b01; 2'b10 and 2'b11 are treated as `RD_ALU`.
REQ-007 SHALL provide ports `rdWriteEnable`, input, 1, the execute-registered write enable.
REQ-008 SHALL provide ports `funct3`, input, 3, the execute-registered load width/sign code.
REQ-009 SHALL provide ports `memReadData`, input, 32, the SRAM read word for `aluResult[31:2]`, valid in this cycle.
REQ-010 SHALL provide ports `stall`, input, 1, hold writeback registers.
REQ-011 SHALL provide ports `flush`, input, 1, insert a bubble into writeback.
REQ-012 SHALL provide ports `wbRdAddr`, output, 5, registered destination to writeback.
REQ-013 SHALL provide ports `wbRdData`, output, 32, registered final rd value.
REQ-014 SHALL provide ports `wbRdWriteEnable`, output, 1, registered write enable.
REQ-015 SHALL provide ports `fwdRdAddr`, `fwdRdWriteEnable`, `fwdIsLoad`, output, 5/1/1, combinational forwarding taps of the current-stage inputs.
REQ-016 SHALL provide ports `misalignedLoad`, output, 1, sticky load-fault flag.

Function
REQ-017 SHALL use byte offset `aluResult[1:0]`.
REQ-018 SHALL implement LB (000) as the selected byte, sign-extended.
REQ-019 SHALL implement LBU (100) as the selected byte, zero-extended.
REQ-020 SHALL implement LH (001) and LHU (101) as the halfword at offset 0 or 2, sign-extended for LH and zero-extended for LHU.
REQ-021 SHALL implement LW (010) as the full word.
REQ-022 SHALL define a load fault as `rdSource==RD_MEM` AND (LH/LHU at offset 1 or 3, OR LW at offset ≠0, OR funct3 ∈ {011,110,111}).
REQ-023 SHALL, on a fault, treat the loaded value as 0, force `wbRdWriteEnable` to 0 for that instruction, and set `misalignedLoad` on the capturing edge.
REQ-024 SHALL hold `misalignedLoad` at 1 until reset.
REQ-025 SHALL ignore a fault while `stall` is high.
REQ-026 SHALL select the final rd value as the extended load when `rdSource==RD_MEM`, otherwise `aluResult`.
REQ-027 SHALL register the writeback outputs on each rising edge with a latency of one cycle.
REQ-028 SHALL apply `wbRdWriteEnable` <= `rdWriteEnable` AND NOT fault.
REQ-029 SHALL force `wbRdWriteEnable` to 0 when the destination register is x0, while `wbRdAddr` still captures 0.
REQ-030 SHALL, when `stall`=1 and `flush`=0, hold all writeback registers and the sticky flag unchanged.
REQ-031 SHALL, when `flush`=1, clear `wbRdWriteEnable` on the edge while `wbRdAddr` and `wbRdData` remain don't-care; `flush` has priority over `stall`.
REQ-032 SHALL drive `fwdRdAddr`=`rdAddr`, `fwdRdWriteEnable`=`rdWriteEnable` AND (`rdAddr`≠0), and `fwdIsLoad`=(`rdSource==RD_MEM`) combinationally so the hazard unit can stall load-use.

Reset
REQ-033 SHALL, while `reset` is high, asynchronously drive `wbRdWriteEnable`=0, `wbRdAddr`=0, `wbRdData`=0 and `misalignedLoad`=0.
REQ-034 SHALL drop an instruction present in the stage when reset asserts, with no partial write.
REQ-035 SHALL capture normally on the first rising edge after reset deassertion.

Structure
REQ-036 SHALL place `rd_source_t`, the funct3 load codes, and the x0 address constant in the shared `jzjpcc_pkg`.
REQ-037 SHALL implement the load extraction (offset, width, sign, and the fault signal) as a combinational sub-module `jzjpcc_load_extractor`.
REQ-038 SHALL keep `jzjpcc_memory` itself to the writeback registers, the sticky flag, stall/flush priority, and the forwarding taps.

Verification
REQ-039 SHALL verify: LB with addr 0x103, word 0x80FF1234, `RD_MEM` -> one edge later `wbRdData`=0xFFFFFF80 and `wbRdWriteEnable`=1.
REQ-040 SHALL verify: LHU with addr 0x102, word 0xBEEF0001 -> `wbRdData`=0x0000BEEF; LH at the same address -> 0xFFFFBEEF.
REQ-041 SHALL verify: LW with addr 0x101 -> `wbRdWriteEnable`=0 and `misalignedLoad`=1, which stays 1 through 10 following legal instructions.
REQ-042 SHALL verify: ALU op with rd=5, aluResult=0x12345678, `stall`=1 for 3 cycles -> outputs hold their prior values, then capture 0x12345678 on the first unstalled edge.
REQ-043 SHALL verify: `stall`=1 and `flush`=1 together -> `wbRdWriteEnable`=0 after the edge; rd=0 write -> `wbRdWriteEnable`=0 and `fwdRdWriteEnable`=0.
REQ-044 SHALL verify: `reset` asserted mid-cycle with `wbRdWriteEnable`=1 -> the outputs and the flag clear immediately without waiting for a clock edge.
